// File: rtl/fc_ctrl_pkg.sv
// Shared types and constants for the fc training controller.
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FWD_ISSUE = 3'd1,
        FWD_WAIT  = 3'd2,
        BK_ISSUE  = 3'd3,
        BK_WAIT   = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/fc_train_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR that advances on every clock.
module lfsr8
    import fc_ctrl_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    output logic [7:0] rnd_out
);

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rnd_out <= LFSR_SEED;
        end else begin
            rnd_out <= {rnd_out[6:0], ^(rnd_out & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/fc_train_ctrl.sv
// Sequences one forward (and optionally backward) pass of the fc datapath per sample.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a sample; accept latches x, y, train_en
// FWD_ISSUE | launch forward propagation, clear wait counter
// FWD_WAIT  | wait for fd_prop_done, capture result/error; timeout -> IDLE
// BK_ISSUE  | launch backward propagation, clear wait counter
// BK_WAIT   | wait for bk_prop_done, toggle oscillator; timeout -> IDLE
// DONE      | pulse result_valid, bump sample_count
module fc_train_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int N       = 27,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic [N-1:0]             sample_x,
    input  logic [N-1:0]             sample_y,
    input  logic                     train_en,
    output logic                     fd_prop,
    input  logic                     fd_prop_done,
    output logic                     bk_prop,
    input  logic                     bk_prop_done,
    output logic [N-1:0]             fin,
    output logic [N-1:0]             bin,
    input  logic [N-1:0]             fout,
    output logic                     oscillator,
    output logic [7:0]               rnd_out,
    output logic                     result_valid,
    output logic [N-1:0]             result_out,
    output logic [$clog2(N+1)-1:0]   err_count,
    output logic [CNT_W-1:0]         sample_count,
    output logic                     timeout_err
);

    localparam int EW = $clog2(N+1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    function automatic logic [EW-1:0] popcnt(input logic [N-1:0] v);
        logic [EW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + EW'(v[i]);
        end
        return c;
    endfunction

    state_t          state, state_nxt;
    logic [N-1:0]    y_q;
    logic            train_q;
    logic [TW-1:0]   wait_cnt;
    logic            accept, fwd_hit, bk_hit, expired;

    assign sample_ready = (state == IDLE);

    // Next-state decode; a done in the timeout cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fwd_hit   = 1'b0;
        bk_hit    = 1'b0;
        expired   = 1'b0;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    accept    = 1'b1;
                    state_nxt = FWD_ISSUE;
                end
            end
            FWD_ISSUE: state_nxt = FWD_WAIT;
            FWD_WAIT: begin
                if (fd_prop_done) begin
                    fwd_hit   = 1'b1;
                    state_nxt = train_q ? BK_ISSUE : DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    expired   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BK_ISSUE: state_nxt = BK_WAIT;
            BK_WAIT: begin
                if (bk_prop_done) begin
                    bk_hit    = 1'b1;
                    state_nxt = DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    expired   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered pulses, sample latches, wait counter and result capture.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fd_prop      <= 1'b0;
            bk_prop      <= 1'b0;
            result_valid <= 1'b0;
            oscillator   <= 1'b0;
            timeout_err  <= 1'b0;
            fin          <= '0;
            bin          <= '0;
            y_q          <= '0;
            train_q      <= 1'b0;
            result_out   <= '0;
            err_count    <= '0;
            sample_count <= '0;
            wait_cnt     <= '0;
        end else begin
            fd_prop      <= (state == FWD_ISSUE);
            bk_prop      <= (state == BK_ISSUE);
            result_valid <= (state == DONE);
            if (accept) begin
                fin     <= sample_x;
                y_q     <= sample_y;
                train_q <= train_en;
            end
            if (state == FWD_ISSUE || state == BK_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == FWD_WAIT || state == BK_WAIT) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (fwd_hit) begin
                result_out <= fout;
                bin        <= fout ^ y_q;
                err_count  <= popcnt(fout ^ y_q);
            end
            if (bk_hit) begin
                oscillator <= ~oscillator;
            end
            if (expired) begin
                timeout_err <= 1'b1;
            end
            if (state == DONE) begin
                sample_count <= sample_count + CNT_W'(1);
            end
        end
    end

    lfsr8 u_lfsr8 (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rnd_out (rnd_out)
    );

endmodule

// File: tb/tb_fc_train_ctrl.sv
// Directed bench for fc_train_ctrl (TIMEOUT shortened to 8).
module tb_fc_train_ctrl;

    localparam int N = 27;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid, train_en, fd_prop_done, bk_prop_done;
    logic [N-1:0]  sample_x, sample_y, fout;
    logic          sample_ready, fd_prop, bk_prop, oscillator, result_valid, timeout_err;
    logic [N-1:0]  fin, bin, result_out;
    logic [7:0]    rnd_out;
    logic [4:0]    err_count;
    logic [15:0]   sample_count;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_pulses = 0;
    int bk_pulses = 0;
    int rv_pulses = 0;

    fc_train_ctrl #(.N(N), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .train_en     (train_en),
        .fd_prop      (fd_prop),
        .fd_prop_done (fd_prop_done),
        .bk_prop      (bk_prop),
        .bk_prop_done (bk_prop_done),
        .fin          (fin),
        .bin          (bin),
        .fout         (fout),
        .oscillator   (oscillator),
        .rnd_out      (rnd_out),
        .result_valid (result_valid),
        .result_out   (result_out),
        .err_count    (err_count),
        .sample_count (sample_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Count pulses seen at each rising edge (pre-edge values).
    always @(posedge clk) begin
        if (fd_prop)      fd_pulses <= fd_pulses + 1;
        if (bk_prop)      bk_pulses <= bk_pulses + 1;
        if (result_valid) rv_pulses <= rv_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rnd"},   32'(rnd_out), 32'hA5);
        chk({tag, "_ready"}, 32'(sample_ready), 32'd1);
        chk({tag, "_fd"},    32'(fd_prop), 32'd0);
        chk({tag, "_bk"},    32'(bk_prop), 32'd0);
        chk({tag, "_rv"},    32'(result_valid), 32'd0);
        chk({tag, "_osc"},   32'(oscillator), 32'd0);
        chk({tag, "_terr"},  32'(timeout_err), 32'd0);
        chk({tag, "_fin"},   32'(fin), 32'd0);
        chk({tag, "_bin"},   32'(bin), 32'd0);
        chk({tag, "_res"},   32'(result_out), 32'd0);
        chk({tag, "_err"},   32'(err_count), 32'd0);
        chk({tag, "_cnt"},   32'(sample_count), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0; train_en = 1'b0;
        fd_prop_done = 1'b0; bk_prop_done = 1'b0;
        sample_x = '0; sample_y = '0; fout = '0;

        // Reset state
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // LFSR sequence from seed A5
        tick(); chk("lfsr1", 32'(rnd_out), 32'h4A);
        tick(); chk("lfsr2", 32'(rnd_out), 32'h95);
        tick(); chk("lfsr3", 32'(rnd_out), 32'h2A);

        // A: forward only, done 2 cycles after fd_prop
        sample_x = 27'h1; sample_y = 27'h3; train_en = 1'b0; sample_valid = 1'b1;
        tick(); sample_valid = 1'b0;                       // accept edge t0
        chk("a_ready_busy", 32'(sample_ready), 32'd0);
        chk("a_fd_early", 32'(fd_prop), 32'd0);
        tick();                                            // t1
        chk("a_fd", 32'(fd_prop), 32'd1);
        chk("a_fin", 32'(fin), 32'h1);
        tick();                                            // t2
        chk("a_fd_off", 32'(fd_prop), 32'd0);
        fd_prop_done = 1'b1; fout = 27'h1;
        tick(); fd_prop_done = 1'b0;                       // t3
        chk("a_bin", 32'(bin), 32'h2);
        chk("a_err", 32'(err_count), 32'd1);
        chk("a_res", 32'(result_out), 32'h1);
        chk("a_rv_early", 32'(result_valid), 32'd0);
        tick();                                            // t4
        chk("a_rv", 32'(result_valid), 32'd1);
        chk("a_cnt", 32'(sample_count), 32'd1);
        chk("a_ready", 32'(sample_ready), 32'd1);
        tick();
        chk("a_rv_off", 32'(result_valid), 32'd0);
        chk("a_bk_none", 32'(bk_pulses), 32'd0);
        chk("a_fd_once", 32'(fd_pulses), 32'd1);
        chk("a_rv_once", 32'(rv_pulses), 32'd1);

        // B: forward + backward, bk done 2 cycles after bk_prop
        train_en = 1'b1; sample_valid = 1'b1;
        tick(); sample_valid = 1'b0;                       // t0
        tick();                                            // t1
        tick();                                            // t2
        fd_prop_done = 1'b1;
        tick(); fd_prop_done = 1'b0;                       // t3
        chk("b_bk_early", 32'(bk_prop), 32'd0);
        tick();                                            // t4
        chk("b_bk", 32'(bk_prop), 32'd1);
        tick();                                            // t5
        chk("b_bk_off", 32'(bk_prop), 32'd0);
        bk_prop_done = 1'b1;
        tick(); bk_prop_done = 1'b0;                       // t6
        chk("b_osc", 32'(oscillator), 32'd1);
        chk("b_rv_early", 32'(result_valid), 32'd0);
        tick();                                            // t7
        chk("b_rv", 32'(result_valid), 32'd1);
        chk("b_cnt", 32'(sample_count), 32'd2);
        tick();
        chk("b_bk_once", 32'(bk_pulses), 32'd1);
        chk("b_rv_total", 32'(rv_pulses), 32'd2);

        // D: done arrives in the timeout cycle -> normal completion
        sample_x = 27'h0; sample_y = 27'h7FFFFFF; train_en = 1'b0; sample_valid = 1'b1;
        tick(); sample_valid = 1'b0; fout = 27'h0F0;       // t0
        tick();                                            // t1
        repeat (7) tick();                                 // t8
        chk("d_terr_pre", 32'(timeout_err), 32'd0);
        chk("d_busy", 32'(sample_ready), 32'd0);
        fd_prop_done = 1'b1;
        tick(); fd_prop_done = 1'b0;                       // t9
        chk("d_bin", 32'(bin), 32'h7FFFF0F);
        chk("d_err", 32'(err_count), 32'd23);
        chk("d_res", 32'(result_out), 32'h0F0);
        chk("d_terr", 32'(timeout_err), 32'd0);
        tick();                                            // t10
        chk("d_rv", 32'(result_valid), 32'd1);
        chk("d_cnt", 32'(sample_count), 32'd3);

        // C: fd_prop_done never returned -> timeout 8 cycles after fd_prop
        tick();
        sample_x = 27'h5; sample_y = 27'h0; sample_valid = 1'b1;
        tick(); sample_valid = 1'b0;                       // t0
        tick();                                            // t1 (fd_prop)
        repeat (7) tick();                                 // t8
        chk("c_terr_pre", 32'(timeout_err), 32'd0);
        chk("c_busy", 32'(sample_ready), 32'd0);
        tick();                                            // t9
        chk("c_terr", 32'(timeout_err), 32'd1);
        chk("c_idle", 32'(sample_ready), 32'd1);
        chk("c_cnt", 32'(sample_count), 32'd3);
        tick(); tick();
        chk("c_terr_sticky", 32'(timeout_err), 32'd1);
        chk("c_no_rv", 32'(rv_pulses), 32'd3);
        chk("c_res_held", 32'(result_out), 32'h0F0);

        // E: stray bk_prop_done in IDLE, then reset during FWD_WAIT
        bk_prop_done = 1'b1;
        tick(); bk_prop_done = 1'b0;
        chk("e_stray_idle", 32'(sample_ready), 32'd1);
        tick();
        chk("e_stray_bk", 32'(bk_pulses), 32'd1);
        chk("e_stray_fd", 32'(fd_pulses), 32'd4);
        sample_x = 27'h1; sample_y = 27'h3; train_en = 1'b1; sample_valid = 1'b1;
        tick(); sample_valid = 1'b0;                       // t0
        tick();                                            // t1
        tick();                                            // t2, in FWD_WAIT
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid");
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("e_abort_rv", 32'(rv_pulses), 32'd3);
        chk("e_idle", 32'(sample_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
